cmos_pattern_gen: RTL and testbench

CMOS_PATTERN_GEN -- requirements
Module: cmos_pattern_gen

---
 rtl/cmos_pattern_pkg.sv | 53 +++++
 rtl/cmos_pattern_timing.sv | 151 +++++++++++++++
 rtl/cmos_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_cmos_pattern_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pattern_pkg.sv
// Shared definitions for the CMOS test-pattern generator: register map, pattern codes,
// timing FSM encoding, reset defaults and small datapath helpers.
package cmos_pattern_pkg;

  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegSize   = 3'd1;
  localparam logic [2:0] RegBlank  = 3'd2;
  localparam logic [2:0] RegConst  = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  typedef enum logic [1:0] {
    PatConst   = 2'd0,
    PatColumn  = 2'd1,
    PatRow     = 2'd2,
    PatChecker = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StVsync  = 3'd1,
    StVblank = 3'd2,
    StLsync  = 3'd3,
    StActive = 3'd4,
    StHblank = 3'd5
  } state_e;

  localparam logic [9:0] WidthM1Default  = 10'd639;
  localparam logic [9:0] HeightM1Default = 10'd511;
  localparam logic [7:0] HblankDefault   = 8'd16;
  localparam logic [7:0] VblankDefault   = 8'd4;

  function automatic logic [31:0] wb_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                           input logic [3:0] sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [15:0] pattern_pixel(input pattern_e pat, input logic [9:0] x,
                                                input logic [9:0] y, input logic [15:0] cst);
    logic [15:0] pix;
    case (pat)
      PatConst:  pix = cst;
      PatColumn: pix = {6'b0, x};
      PatRow:    pix = {6'b0, y};
      default:   pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/cmos_pattern_timing.sv
// Frame timing FSM for the pattern generator: sync/blank sequencing plus column, row and
// blanking counters. Geometry is sampled into shadow registers as each frame starts.
module cmos_pattern_timing
  import cmos_pattern_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       oneshot_i,
  input  logic [9:0] width_m1_i,
  input  logic [9:0] height_m1_i,
  input  logic [7:0] hblank_i,
  input  logic [7:0] vblank_i,
  output logic       vsync_o,
  output logic       hsync_o,
  output logic       valid_o,
  output logic       valid_next_o,
  output logic [9:0] x_next_o,
  output logic [9:0] y_next_o,
  output logic       frame_start_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [7:0]  vline_q, vline_d;
  logic [10:0] vcyc_q, vcyc_d;
  logic [9:0]  width_m1_s_q, height_m1_s_q;
  logic [7:0]  hblank_s_q, vblank_s_q;
  logic        vsync_q, hsync_q, valid_q;
  logic        line_end;
  logic        frame_done;
  logic [10:0] line_last;

  // A vertical blank line is as long as a full active line: LSYNC + width + hblank.
  assign line_last = {1'b0, width_m1_s_q} + {3'b0, hblank_s_q} + 11'd1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    hcnt_d     = hcnt_q;
    vline_d    = vline_q;
    vcyc_d     = vcyc_q;
    line_end   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_i) state_d = StVsync;
      end
      StVsync: begin
        y_d = '0;
        if (vblank_s_q != 8'd0) begin
          state_d = StVblank;
          vline_d = '0;
          vcyc_d  = '0;
        end else begin
          state_d = StLsync;
        end
      end
      StVblank: begin
        if (vcyc_q == line_last) begin
          vcyc_d = '0;
          if (vline_q == vblank_s_q - 8'd1) state_d = StLsync;
          else vline_d = vline_q + 8'd1;
        end else begin
          vcyc_d = vcyc_q + 11'd1;
        end
      end
      StLsync: begin
        state_d = StActive;
        x_d     = '0;
      end
      StActive: begin
        if (x_q == width_m1_s_q) begin
          if (hblank_s_q != 8'd0) begin
            state_d = StHblank;
            hcnt_d  = '0;
          end else begin
            line_end = 1'b1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      StHblank: begin
        if (hcnt_q == hblank_s_q - 8'd1) line_end = 1'b1;
        else hcnt_d = hcnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    if (line_end) begin
      if (y_q == height_m1_s_q) begin
        frame_done = 1'b1;
        state_d    = (enable_i && !oneshot_i) ? StVsync : StIdle;
      end else begin
        y_d     = y_q + 10'd1;
        state_d = StLsync;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      hcnt_q        <= '0;
      vline_q       <= '0;
      vcyc_q        <= '0;
      width_m1_s_q  <= WidthM1Default;
      height_m1_s_q <= HeightM1Default;
      hblank_s_q    <= HblankDefault;
      vblank_s_q    <= VblankDefault;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hcnt_q  <= hcnt_d;
      vline_q <= vline_d;
      vcyc_q  <= vcyc_d;
      if (state_d == StVsync) begin
        width_m1_s_q  <= width_m1_i;
        height_m1_s_q <= height_m1_i;
        hblank_s_q    <= hblank_i;
        vblank_s_q    <= vblank_i;
      end
      vsync_q <= (state_d == StVsync);
      hsync_q <= (state_d == StLsync);
      valid_q <= (state_d == StActive);
    end
  end

  assign vsync_o       = vsync_q;
  assign hsync_o       = hsync_q;
  assign valid_o       = valid_q;
  assign valid_next_o  = (state_d == StActive);
  assign x_next_o      = x_d;
  assign y_next_o      = y_d;
  assign frame_start_o = (state_d == StVsync);
  assign frame_done_o  = frame_done;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: rtl/cmos_pattern_gen.sv
// CMOS camera test-pattern generator with a Wishbone classic register port.
// Define CMOS_PATTERN_GEN_FRAME_CNT_EN to stamp the frame count into pixel (0,0) of every frame.
module cmos_pattern_gen
  import cmos_pattern_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [15:0] cmos_data_o,
  output logic        cmos_vsync_o,
  output logic        cmos_hsync_o,
  output logic        cmos_valid_o
);

  logic        enable_q, enable_d;
  logic        oneshot_q, oneshot_d;
  pattern_e    pattern_q, pattern_d;
  logic [9:0]  width_m1_q, width_m1_d;
  logic [9:0]  height_m1_q, height_m1_d;
  logic [7:0]  hblank_q, hblank_d;
  logic [7:0]  vblank_q, vblank_d;
  logic [15:0] const_q, const_d;
  logic [15:0] frame_cnt_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [15:0] data_q, data_d;
  pattern_e    pattern_s_q;
  logic [15:0] const_s_q;

  logic        wb_req, wb_wr;
  logic [2:0]  reg_sel;
  logic [31:0] rdata, wr_merged;
  logic        sig_unused;

  logic       valid_next, frame_start, frame_done, busy;
  logic [9:0] x_next, y_next;

  assign wb_req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_wr      = wb_req & wb_we_i;
  assign reg_sel    = wb_adr_i[4:2];
  assign sig_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wr_merged[31:26]};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegCtrl:   rdata = {28'b0, pattern_q, oneshot_q, enable_q};
      RegSize:   rdata = {6'b0, height_m1_q, 6'b0, width_m1_q};
      RegBlank:  rdata = {8'b0, vblank_q, 8'b0, hblank_q};
      RegConst:  rdata = {16'b0, const_q};
      RegStatus: rdata = {busy, 15'b0, frame_cnt_q};
      default:   rdata = '0;
    endcase
  end

  // Merging against the readback value keeps reserved bits at zero.
  assign wr_merged = wb_merge(rdata, wb_dat_i, wb_sel_i);

  always_comb begin
    enable_d    = enable_q;
    oneshot_d   = oneshot_q;
    pattern_d   = pattern_q;
    width_m1_d  = width_m1_q;
    height_m1_d = height_m1_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    const_d     = const_q;
    if (wb_wr) begin
      case (reg_sel)
        RegCtrl: begin
          pattern_d = pattern_e'(wr_merged[3:2]);
          oneshot_d = wr_merged[1];
          enable_d  = wr_merged[0];
        end
        RegSize: begin
          height_m1_d = wr_merged[25:16];
          width_m1_d  = wr_merged[9:0];
        end
        RegBlank: begin
          vblank_d = wr_merged[23:16];
          hblank_d = wr_merged[7:0];
        end
        RegConst: const_d = wr_merged[15:0];
        default: ;
      endcase
    end
    // A finished one-shot frame disarms the generator, overriding a coincident write.
    if (frame_done && oneshot_q) enable_d = 1'b0;
  end

  always_comb begin
    data_d = '0;
    if (valid_next) begin
`ifdef CMOS_PATTERN_GEN_FRAME_CNT_EN
      if (x_next == 10'd0 && y_next == 10'd0) data_d = frame_cnt_q;
      else data_d = pattern_pixel(pattern_s_q, x_next, y_next, const_s_q);
`else
      data_d = pattern_pixel(pattern_s_q, x_next, y_next, const_s_q);
`endif
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      enable_q    <= 1'b0;
      oneshot_q   <= 1'b0;
      pattern_q   <= PatConst;
      width_m1_q  <= WidthM1Default;
      height_m1_q <= HeightM1Default;
      hblank_q    <= HblankDefault;
      vblank_q    <= VblankDefault;
      const_q     <= '0;
      frame_cnt_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      data_q      <= '0;
      pattern_s_q <= PatConst;
      const_s_q   <= '0;
    end else begin
      enable_q    <= enable_d;
      oneshot_q   <= oneshot_d;
      pattern_q   <= pattern_d;
      width_m1_q  <= width_m1_d;
      height_m1_q <= height_m1_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      const_q     <= const_d;
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      ack_q       <= wb_req;
      dat_q       <= (wb_req && !wb_we_i) ? rdata : 32'd0;
      data_q      <= data_d;
      if (frame_start) begin
        pattern_s_q <= pattern_q;
        const_s_q   <= const_q;
      end
    end
  end

  cmos_pattern_timing u_timing (
    .clk_i         (wb_clk_i),
    .rst_i         (wb_rst_i),
    .enable_i      (enable_q),
    .oneshot_i     (oneshot_q),
    .width_m1_i    (width_m1_q),
    .height_m1_i   (height_m1_q),
    .hblank_i      (hblank_q),
    .vblank_i      (vblank_q),
    .vsync_o       (cmos_vsync_o),
    .hsync_o       (cmos_hsync_o),
    .valid_o       (cmos_valid_o),
    .valid_next_o  (valid_next),
    .x_next_o      (x_next),
    .y_next_o      (y_next),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .busy_o        (busy)
  );

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign cmos_data_o = data_q;

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// Self-checking bench for cmos_pattern_gen: register table vectors plus directed frame sequences.
module tb_cmos_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic [15:0] cmos_data;
  logic        vsync, hsync, valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  reg_idx;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp_read;
  } reg_vec_t;

  reg_vec_t vecs[12];

  always #5 clk = ~clk;

  cmos_pattern_gen dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_dat_o     (wb_dat_r),
    .wb_ack_o     (wb_ack),
    .cmos_data_o  (cmos_data),
    .cmos_vsync_o (vsync),
    .cmos_hsync_o (hsync),
    .cmos_valid_o (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {13'b0, vsync, hsync, valid, cmos_data};
  endfunction

  function automatic logic [31:0] exp_vec(input logic vs, input logic hs, input logic vd,
                                          input logic [15:0] d);
    return {13'b0, vs, hs, vd, d};
  endfunction

  function automatic logic [15:0] exp_pix(input int pat, input int x, input int y,
                                          input logic [15:0] cst, input int fidx);
    logic [15:0] p;
    case (pat)
      0:       p = cst;
      1:       p = 16'(x);
      2:       p = 16'(y);
      default: p = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef CMOS_PATTERN_GEN_FRAME_CNT_EN
    if (x == 0 && y == 0) p = 16'(fidx);
`endif
    return p;
  endfunction

  task automatic wb_xfer(input logic [2:0] idx, input logic [31:0] wdat, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_adr   = {27'b0, idx, 2'b00};
    wb_dat_w = wdat;
    wb_sel   = sel;
    wb_we    = we;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_ack && n < 16);
    check("wb_ack", {31'b0, wb_ack}, 32'd1);
    rdat = wb_dat_r;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_xfer(idx, wdat, 4'hF, 1'b1, dummy);
  endtask

  task automatic wb_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(idx, 32'h0, 4'hF, 1'b0, r);
    check(name, r, exp);
  endtask

  task automatic wait_vsync(input string name);
    int n = 0;
    @(negedge clk);
    while (!vsync && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, out_vec(), exp_vec(1'b1, 1'b0, 1'b0, 16'h0));
  endtask

  task automatic wait_hsyncs(input int target);
    int cnt = 0;
    int n = 0;
    while (cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
      if (hsync) cnt++;
    end
    if (cnt < target) check("hsync_wait", 32'(cnt), 32'(target));
  endtask

  // Checks every cycle after the vsync cycle through the start of the next frame.
  task automatic frame_body(input string name, input int w, input int h, input int vb,
                            input int hb, input int pat, input logic [15:0] cst, input int fidx,
                            input logic exp_next);
    for (int i = 0; i < vb * (w + hb + 1); i++) begin
      @(negedge clk);
      check({name, "_vblank"}, out_vec(), exp_vec(1'b0, 1'b0, 1'b0, 16'h0));
    end
    for (int y = 0; y < h; y++) begin
      @(negedge clk);
      check({name, "_hsync"}, out_vec(), exp_vec(1'b0, 1'b1, 1'b0, 16'h0));
      for (int x = 0; x < w; x++) begin
        @(negedge clk);
        check({name, "_pix"}, out_vec(), exp_vec(1'b0, 1'b0, 1'b1, exp_pix(pat, x, y, cst, fidx)));
      end
      for (int i = 0; i < hb; i++) begin
        @(negedge clk);
        check({name, "_hblank"}, out_vec(), exp_vec(1'b0, 1'b0, 1'b0, 16'h0));
      end
    end
    @(negedge clk);
    check({name, "_next"}, out_vec(), exp_vec(exp_next, 1'b0, 1'b0, 16'h0));
  endtask

  task automatic no_vsync(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (vsync) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic check_defaults(input string tag);
    wb_check({tag, "_ctrl"}, 3'd0, 32'h0000_0000);
    wb_check({tag, "_size"}, 3'd1, 32'h01FF_027F);
    wb_check({tag, "_blank"}, 3'd2, 32'h0004_0010);
    wb_check({tag, "_const"}, 3'd3, 32'h0000_0000);
    wb_check({tag, "_status"}, 3'd4, 32'h0000_0000);
  endtask

  initial begin
    vecs[0]  = '{3'd3, 32'h1234_ABCD, 4'hF, 32'h0000_ABCD};
    vecs[1]  = '{3'd3, 32'h0000_5500, 4'h2, 32'h0000_55CD};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 4'hF, 32'h03FF_03FF};
    vecs[3]  = '{3'd1, 32'h0000_0000, 4'h3, 32'h03FF_0000};
    vecs[4]  = '{3'd1, 32'h00AA_0000, 4'h4, 32'h03AA_0000};
    vecs[5]  = '{3'd1, 32'h0003_0007, 4'hF, 32'h0003_0007};
    vecs[6]  = '{3'd2, 32'hFFFF_FFFF, 4'hF, 32'h00FF_00FF};
    vecs[7]  = '{3'd2, 32'h0002_0001, 4'hF, 32'h0002_0001};
    vecs[8]  = '{3'd4, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[9]  = '{3'd0, 32'h0000_000C, 4'hF, 32'h0000_000C};
    vecs[10] = '{3'd0, 32'hFFFF_FFF0, 4'hF, 32'h0000_0000};
    vecs[11] = '{3'd5, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};

    rst = 1'b1;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'h0);
    check("reset_wb", {wb_ack, wb_dat_r[30:0]}, 32'h0);
    rst = 1'b0;
    check_defaults("reset");

    foreach (vecs[i]) begin
      logic [31:0] r;
      wb_xfer(vecs[i].reg_idx, vecs[i].wdata, vecs[i].sel, 1'b1, r);
      wb_check($sformatf("reg_vec%0d", i), vecs[i].reg_idx, vecs[i].exp_read);
    end

    // Held request: ack must alternate, never two cycles in a row.
    @(negedge clk);
    wb_adr = 32'h0; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ack_held%0d", i), {31'b0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;

    // Width 8, height 4, vblank 2, hblank 1, column pattern, free running.
    wb_write(3'd0, 32'h0000_0005);
    wait_vsync("a_vsync");
    frame_body("a", 8, 4, 2, 1, 1, 16'h0, 0, 1'b1);

    // Disable during row 2: frame still completes, then idle.
    fork
      frame_body("c", 8, 4, 2, 1, 1, 16'h0, 1, 1'b0);
      begin
        wait_hsyncs(3);
        wb_write(3'd0, 32'h0000_0004);
      end
    join
    no_vsync("c_no_vsync", 40);
    wb_check("c_status", 3'd4, 32'h0000_0002);

    // Width change mid-frame applies from the next frame.
    wb_write(3'd0, 32'h0000_0005);
    wait_vsync("d_vsync");
    fork
      frame_body("d1", 8, 4, 2, 1, 1, 16'h0, 2, 1'b1);
      begin
        wait_hsyncs(2);
        wb_write(3'd1, 32'h0003_000F);
        wb_check("d_busy", 3'd4, 32'h8000_0002);
      end
    join
    fork
      frame_body("d2", 16, 4, 2, 1, 1, 16'h0, 3, 1'b0);
      begin
        wait_hsyncs(1);
        wb_write(3'd0, 32'h0000_0004);
      end
    join
    wb_check("d_status", 3'd4, 32'h0000_0004);

    // One-shot constant frame from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wb_write(3'd1, 32'h0003_0007);
    wb_write(3'd2, 32'h0002_0001);
    wb_write(3'd3, 32'h0000_BEEF);
    wb_write(3'd0, 32'h0000_0003);
    wait_vsync("b_vsync");
    frame_body("b", 8, 4, 2, 1, 0, 16'hBEEF, 0, 1'b0);
    no_vsync("b_no_vsync", 30);
    wb_check("b_status", 3'd4, 32'h0000_0001);
    wb_check("b_ctrl", 3'd0, 32'h0000_0002);

    // Reset asserted during active video.
    wb_write(3'd0, 32'h0000_0005);
    wait_vsync("e_vsync");
    begin
      int n = 0;
      while (!valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("e_in_active", {31'b0, valid}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("e_reset_out", out_vec(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_defaults("e");
    no_vsync("e_no_vsync", 30);

    // Zero vblank and zero hblank skip their states.
    wb_write(3'd1, 32'h0001_0003);
    wb_write(3'd2, 32'h0000_0000);
    wb_write(3'd0, 32'h0000_000B);
    wait_vsync("f_vsync");
    frame_body("f", 4, 2, 0, 0, 2, 16'h0, 0, 1'b0);
    wb_check("f_status", 3'd4, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
